hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives PC/IF-ID write enables, the IF/ID flush, the ID/EX bubble (zeroes all control fields entering the ID/EX register) and a global freeze for multi-cycle data-memory accesses.
- Sits beside the ID stage and consumes ID, EX and MEM register-address/control fields.
- Keeps a memory-wait FSM with timeout and saturating stall/flush counters.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM pipeline fields in, stall/flush/freeze controls and counters out.
// The pipeline side drives through "master"; the hazard controller uses "slave".
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_branch;
    logic             id_branch_taken;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_dest;
    logic             mem_mem_read;
    logic [4:0]       mem_dest;
    logic             mem_access;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch, id_branch_taken,
        output ex_mem_read, ex_reg_write, ex_dest,
        output mem_mem_read, mem_dest, mem_access, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
        input  mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch, id_branch_taken,
        input  ex_mem_read, ex_reg_write, ex_dest,
        input  mem_mem_read, mem_dest, mem_access, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
        output mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use/branch stalls, taken-branch flush,
// data-memory wait freeze with timeout, and saturating stall/flush counters.
//
//  state  | meaning
//  S_RUN  | normal flow; stalls, bubbles and flushes decided from current ID/EX/MEM fields
//  S_WAIT | multi-cycle dmem access in flight; whole pipeline frozen until ready or timeout
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
    // Remaining-wait down-counter: loaded when the first frozen cycle ends, timeout at zero.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 2);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_rem, wait_rem_nxt;
    logic              timeout_set;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, br_hazard;

    assign ex_rs  = (hz.ex_dest  != 5'd0) && (hz.ex_dest  == hz.id_rs);
    assign ex_rt  = (hz.ex_dest  != 5'd0) && (hz.ex_dest  == hz.id_rt);
    assign mem_rs = (hz.mem_dest != 5'd0) && (hz.mem_dest == hz.id_rs);
    assign mem_rt = (hz.mem_dest != 5'd0) && (hz.mem_dest == hz.id_rt);

    assign load_use  = hz.ex_mem_read & (ex_rs | (hz.id_uses_rt & ex_rt));
    // Branches compare in ID, so both operands must be final, whatever id_uses_rt says.
    assign br_hazard = hz.id_branch &
                       ((hz.ex_reg_write & (ex_rs | ex_rt)) |
                        (hz.mem_mem_read & (mem_rs | mem_rt)));

    always_comb begin
        state_nxt    = state;
        wait_rem_nxt = wait_rem;
        timeout_set  = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;
        if (!reset) begin
            case (state)
                S_RUN: begin
                    if (hz.mem_access && !hz.dmem_ready) begin
                        freeze       = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        state_nxt    = S_WAIT;
                        wait_rem_nxt = WAIT_LOAD;
                    end else if (load_use || br_hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (hz.id_branch && hz.id_branch_taken) begin
                        if_id_flush  = 1'b1;
                    end
                end
                S_WAIT: begin
                    freeze      = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (hz.dmem_ready) begin
                        state_nxt    = S_RUN;
                        wait_rem_nxt = '0;
                    end else if (wait_rem == '0) begin
                        timeout_set  = 1'b1;
                        state_nxt    = S_RUN;
                    end else begin
                        wait_rem_nxt = wait_rem - WAIT_W'(1);
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            wait_rem    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_rem <= wait_rem_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.freeze       = freeze;
    assign hz.mem_timeout  = mem_timeout;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
endmodule
